// File: rtl/btn_debounce.sv
// btn_debounce: four independent push-button debouncers.
// Each raw button level is synchronized, then qualified by a small FSM that
// only accepts a new level after it has been held for STABLE_CYCLES
// consecutive clocks. Registered outputs provide the debounced level,
// one-cycle press/release pulses, a one-hot digit select and an any-pressed flag.
`timescale 1ns/1ps

module btn_debounce #(
  parameter int unsigned STABLE_CYCLES = 900,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic [3:0] btn_sel,
  output logic       btn_any
);

  // Counter only has to reach STABLE_CYCLES-2, so clog2(STABLE_CYCLES) bits
  // always suffice (minimum one bit for STABLE_CYCLES=2).
  localparam int unsigned CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 2);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_e;

  // True when exactly one bit of a 4-bit vector is set.
  function automatic logic onehot4(input logic [3:0] v);
    logic nonzero;
    logic single;
    nonzero = (v != 4'b0000);
    single  = ((v & (v - 4'd1)) == 4'b0000);
    return nonzero & single;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] sync_s;

  // Metastability chain: stage 0 samples the asynchronous pins, the last stage feeds the FSMs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= 4'b0000;
      end
    end else begin
      sync_q[0] <= btn_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Per-button qualification FSMs
  // ---------------------------------------------------------------------------
  // level_d is the debounced level implied by the current FSM states; the
  // output registers below capture it, which places every output exactly one
  // clock after the FSM reaches the accepting state.
  logic [3:0] level_d;

  for (genvar b = 0; b < 4; b++) begin : g_btn
    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next-state logic: a WAIT state resolves when the count hits CNT_LAST,
    // and any reversal of the synchronized input discards the partial count.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        ST_RELEASED: begin
          if (sync_s[b]) begin
            state_d = ST_PRESS_WAIT;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_RELEASED;
          end
        end
        ST_PRESS_WAIT: begin
          if (!sync_s[b]) begin
            state_d = ST_RELEASED;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_PRESSED;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!sync_s[b]) begin
            state_d = ST_RELEASE_WAIT;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_PRESSED;
          end
        end
        ST_RELEASE_WAIT: begin
          if (sync_s[b]) begin
            state_d = ST_PRESSED;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_RELEASED;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_RELEASED;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end

    // State and counter registers; reset returns the button to RELEASED.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_RELEASED;
        cnt_q   <= CNT_ZERO;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign level_d[b] = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  logic [3:0] level_q;
  logic [3:0] press_q;
  logic [3:0] release_q;
  logic [3:0] sel_q;
  logic       any_q;
  logic [3:0] sel_d;

  // Digit select is only meaningful when a single button is held.
  always_comb begin
    sel_d = 4'b0000;
    if (onehot4(level_d)) begin
      sel_d = level_d;
    end else begin
      sel_d = 4'b0000;
    end
  end

  // Register all outputs from level_d so level, pulses, select and any stay aligned.
  // A pulse is an edge of the debounced level, so an aborted wait never pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= 4'b0000;
      press_q   <= 4'b0000;
      release_q <= 4'b0000;
      sel_q     <= 4'b0000;
      any_q     <= 1'b0;
    end else begin
      level_q   <= level_d;
      press_q   <= level_d & ~level_q;
      release_q <= ~level_d & level_q;
      sel_q     <= sel_d;
      any_q     <= |level_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_sel     = sel_q;
  assign btn_any     = any_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce (STABLE_CYCLES=4, SYNC_STAGES=2).
// Reference model: raw samples are delayed by SS edges, then each bit counts
// consecutive samples that differ from its accepted level; after SC of them
// the accepted level flips. Outputs show the accepted level one edge later.
`timescale 1ns/1ps

module tb_btn_debounce;
  localparam int SC = 4;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_level, btn_press, btn_release, btn_sel;
  logic       btn_any;

  int total = 0;
  int bad   = 0;

  // model state
  logic [3:0] hist [SS];
  logic [3:0] acc;
  int         run [4];
  logic [3:0] e_level, e_press, e_release, e_sel;
  logic       e_any;

  btn_debounce #(.STABLE_CYCLES(SC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_sel(btn_sel), .btn_any(btn_any)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    for (int k = 0; k < SS; k++) hist[k] = 4'b0000;
    for (int i = 0; i < 4; i++) run[i] = 0;
    acc = 4'b0000;
    e_level = 4'b0000; e_press = 4'b0000; e_release = 4'b0000;
    e_sel = 4'b0000; e_any = 1'b0;
  endfunction

  function automatic void model_edge();
    logic [3:0] s;
    logic [3:0] prev;
    if (!rst_n) begin
      model_clear();
    end else begin
      s = hist[SS-1];
      prev = e_level;
      e_level   = acc;
      e_press   = acc & ~prev;
      e_release = ~acc & prev;
      e_sel     = ($countones(acc) == 1) ? acc : 4'b0000;
      e_any     = (acc != 4'b0000);
      for (int i = 0; i < 4; i++) begin
        if (s[i] != acc[i]) begin
          run[i]++;
          if (run[i] == SC) begin
            acc[i] = s[i];
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      for (int k = SS-1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = btn_raw;
    end
  endfunction

  // Drive inputs at the falling edge, advance one rising edge, settle 1ns.
  task automatic tick(input logic [3:0] v, input logic r);
    @(negedge clk);
    btn_raw = v;
    if (r !== rst_n) begin
      rst_n = r;
      if (!r) model_clear();
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_raw = 4'b0000; model_clear();
    #2;
    total++;
    if ({btn_level, btn_press, btn_release, btn_sel, btn_any} !== 17'h0) begin
      bad++; $display("FAIL reset_init got=%h want=%h", {btn_level, btn_press, btn_release, btn_sel, btn_any}, 17'h0);
    end
    apply_reset();
    // press all four, then reset asynchronously while press pulses are high
    for (int e = 0; e <= 6; e++) begin
      tick(4'b1111, 1'b1);
      total++;
      if (btn_press !== ((e == 6) ? 4'b1111 : 4'b0000)) begin
        bad++; $display("FAIL simul_press e=%0d got=%b want=%b", e, btn_press, (e == 6) ? 4'b1111 : 4'b0000);
      end
    end
    #2;
    rst_n = 1'b0; model_clear();
    #1;
    total++;
    if ({btn_level, btn_press, btn_release, btn_sel, btn_any} !== 17'h0) begin
      bad++; $display("FAIL reset_mid_pulse got=%h want=%h", {btn_level, btn_press, btn_release, btn_sel, btn_any}, 17'h0);
    end
    tick(4'b1111, 1'b0);
    tick(4'b0000, 1'b0);
  endtask

  task automatic test_clean_press();
    apply_reset();
    for (int e = 0; e <= 8; e++) begin
      tick(4'b0001, 1'b1);
      total++;
      if ({btn_level, btn_press, btn_release, btn_sel, btn_any} !== {e_level, e_press, e_release, e_sel, e_any}) begin
        bad++; $display("FAIL clean_model e=%0d got=%h want=%h", e, {btn_level, btn_press, btn_release, btn_sel, btn_any}, {e_level, e_press, e_release, e_sel, e_any});
      end
      total++;
      if ({btn_level, btn_sel, btn_any, btn_press} !== ((e >= 6) ? {4'b0001, 4'b0001, 1'b1, (e == 6) ? 4'b0001 : 4'b0000} : 13'h0)) begin
        bad++; $display("FAIL clean_press e=%0d got lvl=%b sel=%b any=%b prs=%b", e, btn_level, btn_sel, btn_any, btn_press);
      end
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    for (int e = 0; e < 12; e++) begin
      tick((e < 2) ? 4'b0100 : 4'b0000, 1'b1);
      total++;
      if ({btn_level, btn_press, btn_release, btn_sel, btn_any} !== 17'h0) begin
        bad++; $display("FAIL glitch e=%0d got=%h want=%h", e, {btn_level, btn_press, btn_release, btn_sel, btn_any}, 17'h0);
      end
    end
  endtask

  task automatic test_bouncy_release();
    logic [3:0] pat;
    int rel_cnt;
    apply_reset();
    rel_cnt = 0;
    for (int e = 0; e <= 24; e++) begin
      if (e < 10)       pat = 4'b0001;
      else if (e < 14)  pat = (e[0]) ? 4'b0001 : 4'b0000; // 0,1,0,1 on single cycles
      else              pat = 4'b0000;                    // last edge = 14
      tick(pat, 1'b1);
      if (btn_release[0]) rel_cnt++;
      if (e >= 6) begin
        total++;
        if (btn_level[0] !== ((e < 20) ? 1'b1 : 1'b0) || btn_release[0] !== ((e == 20) ? 1'b1 : 1'b0)) begin
          bad++; $display("FAIL bouncy_release e=%0d got lvl=%b rel=%b", e, btn_level[0], btn_release[0]);
        end
      end
      total++;
      if ({btn_level, btn_press, btn_release, btn_sel, btn_any} !== {e_level, e_press, e_release, e_sel, e_any}) begin
        bad++; $display("FAIL bouncy_model e=%0d got=%h want=%h", e, {btn_level, btn_press, btn_release, btn_sel, btn_any}, {e_level, e_press, e_release, e_sel, e_any});
      end
    end
    total++;
    if (rel_cnt !== 1) begin
      bad++; $display("FAIL bouncy_pulses got=%0d want=1", rel_cnt);
    end
  endtask

  task automatic test_two_buttons();
    apply_reset();
    for (int e = 0; e <= 18; e++) begin
      tick((e < 10) ? 4'b0001 : 4'b0011, 1'b1);
      if (e == 15) begin
        total++;
        if (btn_sel !== 4'b0001 || btn_level !== 4'b0001) begin
          bad++; $display("FAIL two_before e=15 got sel=%b lvl=%b want sel=0001 lvl=0001", btn_sel, btn_level);
        end
      end
      if (e == 16) begin
        total++;
        if (btn_level !== 4'b0011 || btn_sel !== 4'b0000 || btn_press !== 4'b0010 || btn_any !== 1'b1) begin
          bad++; $display("FAIL two_buttons e=16 got lvl=%b sel=%b prs=%b any=%b", btn_level, btn_sel, btn_press, btn_any);
        end
      end
      total++;
      if ({btn_level, btn_press, btn_release, btn_sel, btn_any} !== {e_level, e_press, e_release, e_sel, e_any}) begin
        bad++; $display("FAIL two_model e=%0d got=%h want=%h", e, {btn_level, btn_press, btn_release, btn_sel, btn_any}, {e_level, e_press, e_release, e_sel, e_any});
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    for (int e = 0; e <= 13; e++) begin
      tick(4'b1000, (e == 3 || e == 4) ? 1'b0 : 1'b1);
      total++;
      if (btn_level !== ((e >= 11) ? 4'b1000 : 4'b0000) || btn_press !== ((e == 11) ? 4'b1000 : 4'b0000)) begin
        bad++; $display("FAIL reset_mid_wait e=%0d got lvl=%b prs=%b", e, btn_level, btn_press);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] v;
    logic r;
    apply_reset();
    v = 4'b0000;
    r = 1'b1;
    for (int e = 0; e < 800; e++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 6) == 0) v[i] = ~v[i];
      end
      if (r) r = ($urandom_range(0, 199) != 0);
      else   r = ($urandom_range(0, 1) == 0);
      tick(v, r);
      total++;
      if ({btn_level, btn_press, btn_release, btn_sel, btn_any} !== {e_level, e_press, e_release, e_sel, e_any}) begin
        bad++; $display("FAIL random e=%0d got=%h want=%h", e, {btn_level, btn_press, btn_release, btn_sel, btn_any}, {e_level, e_press, e_release, e_sel, e_any});
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_bouncy_release();
    test_two_buttons();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter STABLE_CYCLES, default 900: number of consecutive clk cycles a synchronized button must hold a new value before it is accepted; legal range 2..65535.
REQ-002 Parameter SYNC_STAGES, default 2: depth of the input synchronizer flop chain; legal range 2..4.
REQ-003 clk  input  1  board clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 btn_raw  input  4  raw, asynchronous, bouncing push-button levels; bit i = button i.
REQ-006 btn_level  output  4  debounced button levels; 1 = pressed.
REQ-007 btn_press  output  4  one-cycle pulse per bit on accepted press.
REQ-008 btn_release  output  4  one-cycle pulse per bit on accepted release.
REQ-009 btn_sel  output  4  equals btn_level when exactly one bit of btn_level is set, else 4'b0000; feeds the digit-load select of the display stage.
REQ-010 btn_any  output  1  OR of btn_level.

Function
REQ-011 Each bit of btn_raw SHALL pass through its own SYNC_STAGES-deep flop chain; only the last stage (s[i]) is used by downstream logic.
REQ-012 Each button SHALL own an independent 4-state FSM: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT, plus an independent counter wide enough for STABLE_CYCLES-1.
REQ-013 RELEASED: s[i]=1 -> PRESS_WAIT with counter cleared to 0; else stay.
REQ-014 PRESS_WAIT: s[i]=0 -> RELEASED with no output change; s[i]=1 and counter = STABLE_CYCLES-2 -> PRESSED; else counter increments.
REQ-015 PRESSED: s[i]=0 -> RELEASE_WAIT with counter cleared; else stay.
REQ-016 RELEASE_WAIT: s[i]=1 -> PRESSED with no output change; s[i]=0 and counter = STABLE_CYCLES-2 -> RELEASED; else counter increments.
REQ-017 btn_level[i] SHALL be 1 in PRESSED and RELEASE_WAIT and 0 otherwise, and SHALL be registered.
REQ-018 btn_press[i] SHALL be 1 for exactly the one cycle after the PRESS_WAIT->PRESSED transition; btn_release[i] SHALL likewise pulse for PRESSED-side RELEASE_WAIT->RELEASED only.
REQ-019 Latency: btn_raw[i] is stable from rising edge E. btn_level[i] and the matching pulse SHALL update at edge E+SYNC_STAGES+STABLE_CYCLES.
REQ-020 A bounce on s[i] shorter than STABLE_CYCLES cycles SHALL produce no change on any output. Any reversal in a WAIT state SHALL discard the partial count, with no carry-over.
REQ-021 Counters SHALL never wrap. A count reaching STABLE_CYCLES-2 always resolves the WAIT state that cycle.
REQ-022 Buttons are independent. Simultaneous presses SHALL assert all affected btn_press bits in the same cycle.
REQ-023 btn_sel and btn_any SHALL be registered, aligned with btn_level, and carry no extra latency. A second button accepted while one is held SHALL drive btn_sel to 0 from that same cycle.

Reset
REQ-024 rst_n=0 SHALL immediately clear all synchronizer flops, counters and outputs (btn_level, btn_press, btn_release, btn_sel = 4'b0000; btn_any = 0) and force every FSM to RELEASED.
REQ-025 Reset asserted mid-WAIT or mid-pulse SHALL abort the operation without emitting a pulse. After rst_n rises, a held button SHALL be re-qualified with the full REQ-019 latency.

Verification (STABLE_CYCLES=4, SYNC_STAGES=2)
REQ-026 Clean press: btn_raw 0000->0001 at edge 0, then held. Required: btn_level=0001, btn_sel=0001 and btn_any=1 at edge 6; btn_press=0001 for edge 6 only.
REQ-027 Glitch: btn_raw[2]=1 for 2 cycles, then 0. Required: all outputs remain 0.
REQ-028 Bouncy release: with bit 0 held, btn_raw[0] toggles 1-0-1-0 on single cycles, then stays 0. Required: btn_level[0] stays 1 until 6 edges after the last edge; btn_release[0] pulses once.
REQ-029 Two buttons: btn_raw 0001 held; 0011 from edge 10. Required: btn_level=0011, btn_sel=0000 and btn_press=0010 at edge 16.
REQ-030 Reset mid-wait: btn_raw=1000 at edge 0; rst_n low at edge 3, high at edge 5. Required: no pulse; btn_level=1000 at edge 11 at the earliest.
